dither_scan_controller: RTL
===========================

DITHER_SCAN_CONTROLLER -- requirements
Module: dither_scan_controller

Interface
REQ-001 Parameter IMAGEX, default 64, image width in pixels (>=2).
REQ-002 Parameter IMAGEY, default 64, image height in pixels (>=1).
REQ-003 Parameter XW, default $clog2(IMAGEX); YW, default $clog2(IMAGEY); AW, default $clog2(IMAGEX*IMAGEY).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse, begins a frame scan; ignored unless idle.
REQ-007 abort  input  1  level, terminates the frame at the next pixel boundary.
REQ-008 pu_start  output  1  one-cycle pulse, tells the pixel datapath to process the pixel at pix_addr.
REQ-009 pu_done  input  1  one-cycle pulse from the pixel datapath, result ready.
REQ-010 pix_x / pix_y / pix_addr  output  XW / YW / AW  current pixel coordinate and linear address y*IMAGEX+x.
REQ-011 scan_dir  output  1  0 = left-to-right, 1 = right-to-left (error diffusion mirror select).
REQ-012 out_valid  output  1  result write request; out_ready  input  1  sink accepts.
REQ-013 busy  output  1  frame in progress; done  output  1  one-cycle pulse at frame end; aborted  output  1  one-cycle pulse at abort completion.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, WRITE, ADVANCE, FINISH; IDLE exits only on start.
REQ-015 IDLE->ISSUE on start, loading x=0 (or per REQ-024), y=0; busy asserted from the cycle after start.
REQ-016 ISSUE asserts pu_start for exactly one cycle with pix_x/pix_y/pix_addr/scan_dir stable, then moves to WAIT.
REQ-017 WAIT holds until pu_done; pu_done arriving in the same cycle as pu_start is ignored (datapath latency >=1).
REQ-018 WRITE holds out_valid high and pix_* stable until out_valid&&out_ready; out_valid never drops without acceptance.
REQ-019 ADVANCE steps x by +1 (scan_dir=0) or -1 (scan_dir=1); at row end wraps x, increments y; after last pixel of last row goes to FINISH, else ISSUE.
REQ-020 FINISH pulses done one cycle, clears busy, returns to IDLE; minimum per-pixel cost 4 cycles with zero-wait handshakes.
REQ-021 abort sampled in ADVANCE only: if high, go to IDLE, pulse aborted, no done; an in-flight pixel always completes its WRITE.
REQ-022 start while busy is ignored; abort while IDLE is ignored; abort and last-pixel ADVANCE in same cycle: abort wins.
REQ-023 pix_addr is computed from a running counter (+1/-1, row jump), never a multiplier; it equals y*IMAGEX+x at all times.

Reset
REQ-024 On rst low: state IDLE, pix_x=0, pix_y=0, pix_addr=0, scan_dir=0, pu_start=0, out_valid=0, busy=0, done=0, aborted=0; reset mid-frame discards the frame with no done/aborted pulse.

Configuration
REQ-025 Macro DITHER_SERPENTINE_EN defined: odd rows scan right-to-left (x starts at IMAGEX-1, scan_dir=1), even rows left-to-right; pix_addr tracks accordingly.
REQ-026 DITHER_SERPENTINE_EN undefined: every row scans left-to-right, scan_dir tied to 0, decrement logic absent.

Structure
REQ-027 Package dither_pkg holds the FSM state enum, IMAGEX/IMAGEY defaults and coordinate width constants, shared with the pixel datapath.
REQ-028 One sub-module, raster_addr_gen: x/y/address counters with wrap and direction; FSM lives in dither_scan_controller.

Verification
REQ-029 4x2 image, pu_done 1 cycle after pu_start, out_ready=1 -> 8 pu_start pulses, pix_addr 0..7 in order, one done pulse, 32 cycles start-to-done.
REQ-030 Serpentine on, 4x2 image -> row 1 visits addr 7,6,5,4 with scan_dir=1; off -> 4,5,6,7 with scan_dir=0.
REQ-031 out_ready held low 5 cycles on pixel 3 -> out_valid and pix_addr=3 stable for 6 cycles, no extra pu_start.
REQ-032 abort raised during WAIT of pixel 2 -> pixel 2 written, aborted pulses once, no done, busy low, next start restarts at addr 0.
REQ-033 rst low during WAIT of pixel 5 -> all outputs at reset values asynchronously, no done/aborted; start after release scans from addr 0.
REQ-034 start pulsed while busy and abort while IDLE -> no state change, no pulses.

Source files
------------

// File: rtl/dither_pkg.sv
//------------------------------------------------------------------------------
// Module   : dither_pkg
// Purpose  : Shared definitions for the dither scan controller and the pixel
//            datapath: FSM state encoding, image size defaults, width helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dither_pkg;

    // Default image geometry
    localparam int c_IMAGEX_DEFAULT = 64;
    localparam int c_IMAGEY_DEFAULT = 64;

    // Coordinate widths; a degenerate single-row/column image still gets a
    // one-bit counter so no vector collapses to zero width.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_XW_DEFAULT = clog2_min1(c_IMAGEX_DEFAULT);
    localparam int c_YW_DEFAULT = clog2_min1(c_IMAGEY_DEFAULT);
    localparam int c_AW_DEFAULT = clog2_min1(c_IMAGEX_DEFAULT * c_IMAGEY_DEFAULT);

    // Scan controller FSM states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_WRITE   = 3'd3,
        S_ADVANCE = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/raster_addr_gen.sv
//------------------------------------------------------------------------------
// Module   : raster_addr_gen
// Purpose  : Raster x/y/linear-address counters with row wrap and scan
//            direction. The linear address is maintained incrementally
//            (+1, -1 or +IMAGEX at a serpentine row turn), never multiplied.
// Config   : DITHER_SERPENTINE_EN - odd rows scan right-to-left.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module raster_addr_gen
    import dither_pkg::*;
#(
    parameter int IMAGEX = c_IMAGEX_DEFAULT,
    parameter int IMAGEY = c_IMAGEY_DEFAULT,
    parameter int XW     = clog2_min1(IMAGEX),
    parameter int YW     = clog2_min1(IMAGEY),
    parameter int AW     = clog2_min1(IMAGEX * IMAGEY)
)(
    input  logic          clk,
    input  logic          rst,      // asynchronous, active-low
    input  logic          i_load,   // restart at pixel (0,0)
    input  logic          i_step,   // move to the next pixel in scan order
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [AW-1:0] o_addr,
    output logic          o_dir,
    output logic          o_last    // current pixel is the last of the frame
);

    localparam logic [XW-1:0] c_X_LAST = XW'(IMAGEX - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(IMAGEY - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic          w_row_end;

`ifdef DITHER_SERPENTINE_EN
    // Row turn: (IMAGEX-1,y) -> (IMAGEX-1,y+1) and (0,y) -> (0,y+1) both
    // move the linear address by exactly one row.
    localparam logic [AW-1:0] c_ROW = AW'(IMAGEX);

    logic r_dir;

    assign w_row_end = r_dir ? (r_x == '0) : (r_x == c_X_LAST);

    // Counter update: step along the row, or turn and drop one row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_dir  <= 1'b0;
        end else if (i_load) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_dir  <= 1'b0;
        end else if (i_step) begin
            if (w_row_end) begin
                r_y    <= r_y + YW'(1);
                r_addr <= r_addr + c_ROW;
                r_dir  <= ~r_dir;
            end else if (r_dir) begin
                r_x    <= r_x - XW'(1);
                r_addr <= r_addr - AW'(1);
            end else begin
                r_x    <= r_x + XW'(1);
                r_addr <= r_addr + AW'(1);
            end
        end
    end

    assign o_dir = r_dir;
`else
    assign w_row_end = (r_x == c_X_LAST);

    // Counter update: row-major order, so the address always advances by one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + AW'(1);
            if (w_row_end) begin
                r_x <= '0;
                r_y <= r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_dir = 1'b0;
`endif

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = r_addr;
    assign o_last = w_row_end && (r_y == c_Y_LAST);

endmodule

`default_nettype wire

// File: rtl/dither_scan_controller.sv
//------------------------------------------------------------------------------
// Module   : dither_scan_controller
// Purpose  : Frame scan sequencer for an error-diffusion dither datapath.
//            Per pixel: ISSUE (pu_start) -> WAIT (pu_done) -> WRITE
//            (out_valid/out_ready) -> ADVANCE (step, abort check).
// Config   : DITHER_SERPENTINE_EN - serpentine scan (odd rows right-to-left).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dither_scan_controller
    import dither_pkg::*;
#(
    parameter int IMAGEX = c_IMAGEX_DEFAULT,
    parameter int IMAGEY = c_IMAGEY_DEFAULT,
    parameter int XW     = clog2_min1(IMAGEX),
    parameter int YW     = clog2_min1(IMAGEY),
    parameter int AW     = clog2_min1(IMAGEX * IMAGEY)
)(
    input  logic          clk,
    input  logic          rst,        // asynchronous, active-low
    input  logic          start,
    input  logic          abort,
    output logic          pu_start,
    input  logic          pu_done,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [AW-1:0] pix_addr,
    output logic          scan_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    state_t r_state;
    state_t w_next;
    logic   r_aborted;
    logic   w_load;
    logic   w_step;
    logic   w_abort_go;
    logic   w_last;

    raster_addr_gen #(
        .IMAGEX (IMAGEX),
        .IMAGEY (IMAGEY),
        .XW     (XW),
        .YW     (YW),
        .AW     (AW)
    ) u_addr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .o_x    (pix_x),
        .o_y    (pix_y),
        .o_addr (pix_addr),
        .o_dir  (scan_dir),
        .o_last (w_last)
    );

    // State register and the registered abort-completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_aborted <= w_abort_go;
        end
    end

    // Next-state logic; abort is only honoured between pixels so an
    // in-flight pixel always reaches its write, and it beats the last-pixel exit
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_abort_go = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ISSUE;
                    w_load = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (pu_done) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (out_ready) begin
                    w_next = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (abort) begin
                    w_next     = S_IDLE;
                    w_abort_go = 1'b1;
                end else if (w_last) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_ISSUE;
                    w_step = 1'b1;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded straight from the state register
    assign pu_start  = (r_state == S_ISSUE);
    assign out_valid = (r_state == S_WRITE);
    assign done      = (r_state == S_FINISH);
    assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                       (r_state == S_WRITE) || (r_state == S_ADVANCE);
    assign aborted   = r_aborted;

endmodule

`default_nettype wire
